// File: rtl/control_types.sv
// Shared control enumerations for the 5-stage core pipeline.
package control_types;

    // Occupancy of an elastic stage: no payload, main only, or main plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_t;

endpackage : control_types

// File: rtl/sat_counter.sv
// Saturating up-counter used for performance monitoring.
// It stops at all-ones and never wraps back to zero.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;

    // Count up on inc until the all-ones ceiling is reached.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/elastic_pipe_reg.sv
// Elastic inter-stage pipeline register.
// It has a valid/ready handshake and a main register plus a skid register,
// so the stage keeps full throughput under back-pressure. A flush replaces
// the contents with a bubble. A saturating counter tracks stalled cycles.
module elastic_pipe_reg #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] BUBBLE = '0,
    parameter int               CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] stall_count
);

    import control_types::*;

    stage_state_t     state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             in_fire;
    logic             out_fire;
    logic             stall_inc;

    // in_ready depends only on registered state, flush and rst.
    // It never depends combinationally on out_ready.
    assign in_ready  = (state_q != ST_FULL) & ~flush & ~rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Compute the next occupancy and the data moves.
    // Flush has priority and turns the stage into a bubble.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // Register the occupancy and payload storage. Reset empties the stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    // A stall is a held payload that downstream refuses.
    assign stall_inc = out_valid & ~out_ready & ~rst;

    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (stall_inc),
        .count(stall_count)
    );

endmodule : elastic_pipe_reg

// File: tb/tb_elastic_pipe_reg.sv
// Testbench for elastic_pipe_reg. It runs directed steps from the test plan,
// then random traffic, and checks everything against a FIFO-queue model.
module tb_elastic_pipe_reg;

    localparam int          WIDTH  = 32;
    localparam int          CNT_W  = 4;
    localparam logic [31:0] BUBBLE = 32'h13;
    localparam int          CMAX   = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] stall_count;

    int checks = 0;
    int errors = 0;

    // Reference model: the stage is a FIFO holding at most two payloads.
    logic [31:0] mq[$];
    int          mcnt = 0;

    always #5 clk = ~clk;

    elastic_pipe_reg #(
        .WIDTH (WIDTH),
        .BUBBLE(BUBBLE),
        .CNT_W (CNT_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive the inputs, compare the DUT outputs with the
    // model away from the edge, then advance the model across the edge.
    task automatic step(input logic r, input logic f, input logic v,
                        input logic [31:0] d, input logic ordy, input string tag);
        logic        exp_rdy;
        logic        exp_vld;
        logic [31:0] exp_dat;
        logic        ifire;
        logic        ofire;
        @(negedge clk);
        rst       = r;
        flush     = f;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = (mq.size() < 2) && !f && !r;
        exp_vld = (mq.size() > 0);
        exp_dat = exp_vld ? mq[0] : BUBBLE;
        chk({tag, ".in_ready"},  {31'b0, in_ready},  {31'b0, exp_rdy});
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, exp_vld});
        chk({tag, ".out_data"},  out_data,           exp_dat);
        chk({tag, ".stall"},     32'(stall_count),   32'(mcnt));
        ifire = v && exp_rdy;
        ofire = exp_vld && ordy;
        @(posedge clk);
        if (ofire) $display("%0t %s out data=%h", $time, tag, exp_dat);
        if (ifire) $display("%0t %s in  data=%h", $time, tag, d);
        if (r) begin
            mq.delete();
            mcnt = 0;
        end else begin
            if (exp_vld && !ordy && mcnt < CMAX) mcnt++;
            if (f) begin
                mq.delete();
            end else begin
                if (ofire) void'(mq.pop_front());
                if (ifire) mq.push_back(d);
            end
        end
    endtask

    initial begin
        logic        r_v;
        logic        f_v;
        logic        v_v;
        logic        o_v;
        logic [31:0] d_v;
        logic        pend;

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;

        // Reset
        step(1, 0, 0, 32'h0, 1, "rst0");
        step(1, 0, 1, 32'h1, 1, "rst1");
        step(0, 0, 0, 32'h0, 1, "idle");

        // Streaming at full rate
        step(0, 0, 1, 32'h11, 1, "str");
        step(0, 0, 1, 32'h22, 1, "str");
        step(0, 0, 1, 32'h33, 1, "str");
        step(0, 0, 0, 32'h0,  1, "str");
        step(0, 0, 0, 32'h0,  1, "str");
        step(0, 0, 0, 32'h0,  1, "str");

        // Back-pressure: 0xC waits upstream while the stage is full
        step(0, 0, 1, 32'hA, 1, "bp");
        step(0, 0, 1, 32'hB, 0, "bp");
        step(0, 0, 1, 32'hC, 0, "bp");
        step(0, 0, 1, 32'hC, 0, "bp");
        step(0, 0, 1, 32'hC, 1, "bp");
        step(0, 0, 1, 32'hC, 1, "bp");
        step(0, 0, 0, 32'h0, 1, "bp");
        step(0, 0, 0, 32'h0, 1, "bp");
        chk("bp.out_data_bubble", out_data, BUBBLE);

        // Flush while full
        step(0, 0, 1, 32'h1, 0, "flf");
        step(0, 0, 1, 32'h2, 0, "flf");
        step(0, 1, 0, 32'h0, 0, "flf");
        step(0, 0, 0, 32'h0, 1, "flf");
        chk("flf.out_data_bubble", out_data, 32'h13);

        // Flush together with an offered payload
        step(0, 1, 1, 32'h55, 1, "fli");
        step(0, 0, 1, 32'h66, 1, "fli");
        step(0, 0, 0, 32'h0,  1, "fli");
        chk("fli.out_data_66", out_data, 32'h66);
        step(0, 0, 0, 32'h0,  1, "fli");

        // Saturation of the stall counter
        step(0, 0, 1, 32'h99, 0, "sat");
        for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, 0, "sat");
        chk("sat.at_max", 32'(stall_count), 32'd15);
        step(0, 1, 0, 32'h0, 0, "sat");
        step(0, 0, 0, 32'h0, 1, "sat");
        chk("sat.flush_keeps", 32'(stall_count), 32'd15);
        step(1, 0, 0, 32'h0, 1, "sat");
        step(0, 0, 0, 32'h0, 1, "sat");
        chk("sat.rst_clears", 32'(stall_count), 32'd0);

        // Reset mid-operation
        step(0, 0, 1, 32'h77, 0, "rmo");
        step(1, 0, 0, 32'h0,  0, "rmo");
        step(0, 0, 0, 32'h0,  0, "rmo");

        // Random traffic that respects the hold-while-stalled rule
        pend = 1'b0;
        d_v  = '0;
        for (int i = 0; i < 400; i++) begin
            r_v = ($urandom_range(0, 59) == 0);
            f_v = ($urandom_range(0, 19) == 0);
            o_v = ($urandom_range(0, 2) != 0);
            if (pend && $urandom_range(0, 3) != 0) begin
                v_v = 1'b1;
            end else begin
                v_v = ($urandom_range(0, 3) != 0);
                d_v = $urandom;
            end
            pend = v_v && !((mq.size() < 2) && !f_v && !r_v);
            step(r_v, f_v, v_v, d_v, o_v, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_elastic_pipe_reg

// File: doc/elastic_pipe_reg.md
# elastic_pipe_reg

Parametrised elastic pipeline register for the 5-stage core; the next generation of the fixed inter-stage registers. It carries an opaque WIDTH-bit payload and adds a valid/ready handshake, a two-entry skid buffer for full throughput under back-pressure, and bubble insertion on flush. It also has a saturating stall counter for performance monitoring. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB, with control fields packed into the payload by the instantiating stage.

## Interface
Parameters:
- WIDTH, 32: payload width in bits (≥1).
- BUBBLE, '0: payload value presented while the stage is empty. The instantiator sets it to the stage's NOP encoding.
- CNT_W, 32: stall counter width (≥1).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous stage clear; inserts a bubble.
- in_valid  in  1  upstream holds a valid payload.
- in_ready  out  1  stage can accept a payload this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  stage holds a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload; equals BUBBLE whenever out_valid=0.
- stall_count  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.

## Operation
- An input transfer (in_fire) is in_valid & in_ready. An output transfer (out_fire) is out_valid & out_ready.
- Storage is a main register (drives out_data) plus a skid register. State is EMPTY, ONE or FULL.
- in_ready = (state != FULL) & ~flush & ~rst.
- out_valid = (state != EMPTY).
- Transitions from EMPTY:
  - in_fire → ONE; main ← in_data.
- Transitions from ONE:
  - in_fire & out_fire → ONE; main ← in_data.
  - in_fire & ~out_fire → FULL; skid ← in_data.
  - ~in_fire & out_fire → EMPTY; main ← BUBBLE.
  - Otherwise, hold.
- Transitions from FULL:
  - out_fire → ONE; main ← skid; skid ← BUBBLE.
  - Otherwise, hold. No input is accepted while FULL.
- flush: takes priority over every handshake.
  - Next state is EMPTY; main and skid ← BUBBLE.
  - in_ready is 0 that cycle, so no payload is accepted or lost ambiguously.
  - An out_fire in the same cycle still counts as delivered downstream.
  - stall_count is unaffected.
- rst: same effect as flush, and also clears stall_count to 0. rst has priority over flush.
- stall_count: increments by 1 on each cycle where out_valid & ~out_ready & ~rst. It holds at 2^CNT_W−1 and never wraps.
- Payload bits are never interpreted or modified; ordering is strictly FIFO.

## Timing
- Reset values (cycle after rst is sampled high):
  - out_valid=0, out_data=BUBBLE, stall_count=0, state EMPTY.
  - in_ready=0 while rst is high, and 1 in the first cycle after rst is low.
- Latency: an in_fire at edge N makes the payload visible on out_data with out_valid=1 after edge N (one cycle) when the stage was EMPTY, or ONE with a concurrent out_fire.
- Throughput: one transfer per cycle while out_ready=1.
- Back-pressure: one extra payload is absorbed after out_ready falls. in_ready drops the cycle after the stage enters FULL.
- in_ready has a combinational path only from flush/rst; otherwise it is a function of registered state. There is no combinational path from out_ready to in_ready.
- out_data and out_valid are driven directly from registers.
- Upstream must hold in_data stable while in_valid=1 & in_ready=0 (standard valid/ready rule). Dropping in_valid without a transfer is permitted.
- Reset or flush asserted mid-transfer: any payload in main or skid is discarded. The first post-flush in_fire is accepted on the cycle after flush deasserts.

## Structure
- The state enum stage_state_t {ST_EMPTY, ST_ONE, ST_FULL} lives in control_types.sv alongside the existing control enums.
- The saturating counter is a separate sub-module, sat_counter, with parameter W and ports clk, rst, inc, count. It is reused for other performance counters.
- The datapath (main/skid registers and muxes) is inline in elastic_pipe_reg.

## Test plan
- Streaming, WIDTH=32, out_ready=1: push 0x11, 0x22, 0x33 on consecutive cycles → out_data 0x11, 0x22, 0x33 on the following three cycles, out_valid=1 throughout, stall_count=0.
- Back-pressure: push 0xA, 0xB, 0xC with out_ready=0 from the second cycle → 0xA and 0xB held, in_ready=0, 0xC stalled upstream. On out_ready=1, the output order is 0xA, 0xB, 0xC with no loss; stall_count equals the stalled cycles.
- Flush while FULL with BUBBLE=0x13: assert flush for one cycle → out_valid=0 and out_data=0x13 next cycle; in_ready=0 during flush and 1 after; previously held payloads are never output.
- Simultaneous flush and in_valid=1 (0x55): 0x55 is not accepted (in_ready=0). The next in_fire of 0x66 appears on the output one cycle later.
- Saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles → stall_count reaches 15 and stays there. A flush does not clear it; rst sets it to 0 on the next cycle.
- Reset mid-operation: assert rst while in state ONE with 0x77 → out_valid=0, out_data=BUBBLE, in_ready=0 while rst is high, in_ready=1 the first cycle after.
